// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with clear sequencer
//
// Shares the register file's single write port between two writeback
// requesters (A and B) using a valid/ready handshake, and provides a
// hardware sweep that zeroes registers 1..2^SEL_WIDTH-1, one per cycle.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   a_valid/a_sel/a_data   - requester A write request
//   a_ready                - A transfer accepted this cycle (combinational)
//   b_valid/b_sel/b_data   - requester B write request
//   b_ready                - B transfer accepted this cycle (combinational)
//   clear_req              - single-cycle pulse starting the clear sweep
//   clear_busy             - clear sweep in progress (registered)
//   wEn/write_sel/write_data - registered register file write port
//
// Build option: WB_RR_ARB_EN selects round-robin arbitration on ties;
// when undefined, A has fixed priority over B.

module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [SEL_WIDTH-1:0]  a_sel,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [SEL_WIDTH-1:0]  b_sel,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  wEn,
    output logic [SEL_WIDTH-1:0]  write_sel,
    output logic [DATA_WIDTH-1:0] write_data
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = '1;
    localparam logic [SEL_WIDTH-1:0] ONE_SEL  = SEL_WIDTH'(1);

    state_t               state;
    logic [SEL_WIDTH-1:0] clr_cnt;   // next register the sweep will zero
    logic                 arb_open;
    logic                 pick_a;

    // Grants are only possible in ARB, outside reset, and not in the cycle
    // that launches a clear sweep.
    assign arb_open = ~reset & (state == ARB) & ~clear_req;

`ifdef WB_RR_ARB_EN
    logic last_b;   // 1: B won the most recent transfer, so A wins a tie

    assign pick_a = a_valid & (~b_valid | last_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (a_ready) begin
            last_b <= 1'b0;
        end else if (b_ready) begin
            last_b <= 1'b1;
        end
    end
`else
    assign pick_a = a_valid;
`endif

    assign a_ready = arb_open & pick_a;
    assign b_ready = arb_open & b_valid & ~pick_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            clr_cnt    <= ONE_SEL;
            clear_busy <= 1'b0;
            wEn        <= 1'b0;
            write_sel  <= '0;
            write_data <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (clear_req) begin
                        // First sweep write is presented the very next cycle.
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        wEn        <= 1'b1;
                        write_sel  <= clr_cnt;
                        write_data <= '0;
                        clr_cnt    <= clr_cnt + ONE_SEL;
                    end else if (a_ready) begin
                        // Register 0 is hardwired: handshake completes, no write.
                        wEn        <= (a_sel != '0);
                        write_sel  <= a_sel;
                        write_data <= a_data;
                    end else if (b_ready) begin
                        wEn        <= (b_sel != '0);
                        write_sel  <= b_sel;
                        write_data <= b_data;
                    end else begin
                        wEn <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (write_sel == LAST_SEL) begin
                        // Last register is on the port this cycle; sweep ends.
                        state      <= ARB;
                        clear_busy <= 1'b0;
                        wEn        <= 1'b0;
                        clr_cnt    <= ONE_SEL;
                    end else begin
                        wEn        <= 1'b1;
                        write_sel  <= clr_cnt;
                        write_data <= '0;
                        clr_cnt    <= clr_cnt + ONE_SEL;
                    end
                end
                default: begin
                    state <= ARB;
                    wEn   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_sel = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_sel = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        wEn;
    logic [4:0]  write_sel;
    logic [31:0] write_data;

    int total = 0;
    int bad   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_e;
    logic [31:0] rf[0:31];

    regfile_wb_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_sel      (a_sel),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_sel      (b_sel),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .wEn        (wEn),
        .write_sel  (write_sel),
        .write_data (write_data)
    );

    always #5 clock = ~clock;

    // Register file model: register 0 is hardwired to zero.
    always @(posedge clock) begin
        if (wEn && write_sel != 5'd0) rf[write_sel] <= write_data;
    end

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && wEn) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: actual sel=%0d data=%h, required no write",
                         write_sel, write_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({write_sel, write_data} !== exp_e) begin
                    bad++;
                    $display("FAIL wr_seq: actual sel=%0d data=%h, required sel=%0d data=%h",
                             write_sel, write_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_a5();
        for (int r = 1; r < 32; r++) begin
            tick();
            a_valid = 1'b1; a_sel = 5'(r); a_data = 32'hA5A5A5A5;
            #1;
            chk("fill_a_ready", a_ready, 1);
            exp_q.push_back({5'(r), 32'hA5A5A5A5});
        end
        tick();
        a_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ia;
        int ib;
        logic ea;

        for (int r = 0; r < 32; r++) rf[r] = '0;

        // Reset: outputs zero, readies forced low even with requests pending.
        a_valid = 1'b1; b_valid = 1'b1; a_sel = 5'd1; b_sel = 5'd2;
        tick(); tick();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_wen", wEn, 0);
        chk("rst_sel", write_sel, 0);
        chk("rst_data", write_data, 0);
        chk("rst_busy", clear_busy, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b0;

        // Single A write, one-cycle latency.
        tick();
        a_valid = 1'b1; a_sel = 5'd2; a_data = 32'hDEADBEEF;
        #1;
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        exp_q.push_back({5'd2, 32'hDEADBEEF});
        tick();
        a_valid = 1'b0;
        #1;
        chk("t1_wen", wEn, 1);
        chk("t1_sel", write_sel, 2);
        chk("t1_data", write_data, 32'hDEADBEEF);
        tick();
        #1;
        chk("t1_rf2", rf[2], 32'hDEADBEEF);
        chk("t1_wen_low", wEn, 0);
        chk("t1_sel_hold", write_sel, 2);

        // Fresh reset so the pointer starts at last=B, then tie for 4 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ia = 0; ib = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            a_valid = 1'b1; a_sel = 5'd3; a_data = 32'h11 + (ia << 8);
            b_valid = 1'b1; b_sel = 5'd4; b_data = 32'h22 + (ib << 8);
`ifdef WB_RR_ARB_EN
            ea = (k % 2 == 0);
`else
            ea = 1'b1;
`endif
            #1;
            chk("tie_a_ready", a_ready, ea);
            chk("tie_b_ready", b_ready, !ea);
            if (ea) begin
                exp_q.push_back({5'd3, a_data});
                ia++;
            end else begin
                exp_q.push_back({5'd4, b_data});
                ib++;
            end
        end
`ifndef WB_RR_ARB_EN
        // B was stalled throughout; it drains once A drops.
        tick();
        a_valid = 1'b0;
        #1;
        chk("drain_b_ready", b_ready, 1);
        exp_q.push_back({5'd4, 32'h22});
`endif
        tick();
        a_valid = 1'b0; b_valid = 1'b0;

        // Write to register 0: handshake completes, no write enable.
        tick();
        b_valid = 1'b1; b_sel = 5'd0; b_data = 32'hFFFFFFFF;
        #1;
        chk("r0_b_ready", b_ready, 1);
        chk("r0_a_ready", a_ready, 0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("r0_wen", wEn, 0);
        chk("r0_data_reg", write_data, 32'hFFFFFFFF);

        // Full sweep with A pending and a second clear pulse mid-sweep.
        fill_a5();
        tick();
        a_valid = 1'b1; a_sel = 5'd5; a_data = 32'h12345678; clear_req = 1'b1;
        #1;
        chk("clr_req_a_ready", a_ready, 0);
        chk("clr_req_busy", clear_busy, 0);
        for (int r = 1; r < 32; r++) exp_q.push_back({5'(r), 32'h0});
        for (int k = 1; k < 32; k++) begin
            tick();
            clear_req = (k == 5);
            #1;
            chk("clr_a_ready", a_ready, 0);
            chk("clr_busy", clear_busy, 1);
            chk("clr_sel", write_sel, k);
        end
        tick();
        clear_req = 1'b0;
        #1;
        chk("post_clr_busy", clear_busy, 0);
        chk("post_clr_a_ready", a_ready, 1);
        exp_q.push_back({5'd5, 32'h12345678});
        tick();
        a_valid = 1'b0;
        #1;
        chk("post_clr_wen", wEn, 1);
        chk("post_clr_sel", write_sel, 5);
        tick();
        for (int r = 0; r < 32; r++)
            chk("clr_rf", rf[r], (r == 5) ? 32'h12345678 : 32'h0);

        // Reset on the 10th sweep cycle aborts the sweep.
        fill_a5();
        tick();
        clear_req = 1'b1;
        for (int r = 1; r < 10; r++) exp_q.push_back({5'(r), 32'h0});
        for (int k = 1; k < 10; k++) begin
            tick();
            clear_req = 1'b0;
            #1;
            chk("abort_sel", write_sel, k);
        end
        tick();
        reset = 1'b1;
        a_valid = 1'b1; a_sel = 5'd7; a_data = 32'h77;
        #1;
        chk("abort_wen", wEn, 0);
        chk("abort_sel0", write_sel, 0);
        chk("abort_data0", write_data, 0);
        chk("abort_busy", clear_busy, 0);
        chk("abort_a_ready", a_ready, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int r = 1; r < 32; r++)
            chk("abort_rf", rf[r], (r < 10) ? 32'h0 : 32'hA5A5A5A5);
        chk("abort_arb_a_ready", a_ready, 1);
        exp_q.push_back({5'd7, 32'h77});
        tick();
        a_valid = 1'b0;
        #1;
        chk("abort_arb_wen", wEn, 1);
        chk("abort_arb_sel", write_sel, 7);
        tick(); tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
